softmax_recip: RTL and testbench



---
 rtl/softmax_recip_pkg.sv | 19 +
 rtl/softmax_recip_if.sv | 31 +++
 rtl/softmax_recip_div.sv | 57 +++++
 rtl/softmax_recip.sv | 113 +++++++++++
 tb/tb_softmax_recip.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_recip_pkg.sv
// Shared definitions for the softmax datapath: FSM states, fixed-point constants
// and the accumulator width helper used by the reciprocal and multiplier stages.
package softmax_recip_pkg;

    typedef enum logic [1:0] {
        ACC,
        DIV,
        HOLD
    } state_t;

    localparam int FRAC_BITS_DEF = 16;
    localparam int ONE = 1 << FRAC_BITS_DEF;

    // Worst case is N_MAX full-scale elements, so log2(N_MAX) extra bits suffice.
    function automatic int acc_w(input int width, input int n_max);
        return width + $clog2(n_max);
    endfunction

endpackage

// File: rtl/softmax_recip_if.sv
// Streaming input and coefficient output bundle of the softmax reciprocal stage.
interface softmax_recip_if
    import softmax_recip_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 16,
    parameter int N_MAX = 64
);
    localparam int ACC_W = acc_w(WIDTH, N_MAX);

    logic [WIDTH-1:0] DAT_IN;
    logic             DAT_IN_VALID;
    logic             DAT_IN_LAST;
    logic             DAT_IN_READY;
    logic [SHIFT-1:0] SHIFT_VAL;
    logic             SHIFT_VALID;
    logic             SHIFT_READY;
    logic [ACC_W-1:0] SUM_OUT;
    logic             SAT;

    modport master (
        output DAT_IN, DAT_IN_VALID, DAT_IN_LAST, SHIFT_READY,
        input  DAT_IN_READY, SHIFT_VAL, SHIFT_VALID, SUM_OUT, SAT
    );

    modport slave (
        input  DAT_IN, DAT_IN_VALID, DAT_IN_LAST, SHIFT_READY,
        output DAT_IN_READY, SHIFT_VAL, SHIFT_VALID, SUM_OUT, SAT
    );

endinterface

// File: rtl/softmax_recip_div.sv
// Serial restoring divider: one quotient bit per clock, MSB first, ITER bits total.
module softmax_recip_div #(
    parameter int ACC_W = 38,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] numerator,
    input  logic [ACC_W-1:0] divisor,
    output logic [ITER-1:0]  quotient,
    output logic             done
);
    localparam int CW = $clog2(ITER);

    logic [ACC_W-1:0] rem;
    logic [ACC_W-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [ACC_W:0]   rem_sh;
    logic [ACC_W:0]   diff;
    logic             ge;
    logic [ACC_W-1:0] rem_nx;

    // Remainder stays below the divisor, so the doubled value fits in ACC_W+1
    // bits and the sign of the trial difference is the compare result.
    always_comb begin
        rem_sh = {rem, 1'b0};
        diff   = rem_sh - {1'b0, dvs};
        ge     = ~diff[ACC_W];
        rem_nx = ge ? diff[ACC_W-1:0] : rem_sh[ACC_W-1:0];
        done   = busy && (cnt == CW'(ITER - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= numerator;
            dvs      <= divisor;
            cnt      <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            rem      <= rem_nx;
            quotient <= {quotient[ITER-2:0], ge};
            cnt      <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/softmax_recip.sv
// Accumulates one vector of exponentials and emits floor(2^SHIFT*ONE/SUM) as a coefficient.
// Build option SOFTMAX_RECIP_ROUND_EN: one guard bit and round-half-up of the coefficient.
module softmax_recip
    import softmax_recip_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int SHIFT     = 16,
    parameter int N_MAX     = 64
) (
    input logic            CLK,
    input logic            RST,
    softmax_recip_if.slave bus
);
    localparam int ACC_W = acc_w(WIDTH, N_MAX);
    localparam int CNT_W = $clog2(N_MAX);
`ifdef SOFTMAX_RECIP_ROUND_EN
    localparam int ITER = SHIFT + 1;
`else
    localparam int ITER = SHIFT;
`endif
    localparam logic [ACC_W-1:0] ONE_W = {{(ACC_W-1){1'b0}}, 1'b1} << FRAC_BITS;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             hs;
    logic             vec_end;
    logic [ACC_W-1:0] acc_nx;
    logic             sat_nx;
    logic [ACC_W-1:0] div_dvs;
    logic [ITER-1:0]  quot;
    logic             div_done;
    logic [SHIFT-1:0] coef;
`ifdef SOFTMAX_RECIP_ROUND_EN
    logic [SHIFT:0]   rounded;
`endif

    always_comb begin
        hs      = bus.DAT_IN_VALID && (state_q == ACC);
        acc_nx  = acc_q + ACC_W'(bus.DAT_IN);
        vec_end = hs && (bus.DAT_IN_LAST || (cnt_q == CNT_W'(N_MAX - 1)));
        sat_nx  = (acc_nx <= ONE_W);
        // A saturating sum (including zero) never reaches the divider as divisor.
        div_dvs = sat_nx ? '1 : acc_nx;
    end

    softmax_recip_div #(
        .ACC_W (ACC_W),
        .ITER  (ITER)
    ) u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (vec_end),
        .numerator (ONE_W),
        .divisor   (div_dvs),
        .quotient  (quot),
        .done      (div_done)
    );

    always_comb begin
`ifdef SOFTMAX_RECIP_ROUND_EN
        rounded = {1'b0, quot[ITER-1:1]} + (SHIFT + 1)'(quot[0]);
        coef    = rounded[SHIFT] ? '1 : rounded[SHIFT-1:0];
`else
        coef    = quot;
`endif
        if (sat_q)
            coef = '1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (vec_end) state_d = DIV;
            DIV:     if (div_done) state_d = HOLD;
            HOLD:    if (bus.SHIFT_READY) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        bus.DAT_IN_READY = (state_q == ACC);
        bus.SHIFT_VALID  = (state_q == HOLD);
        bus.SHIFT_VAL    = (state_q == HOLD) ? coef : '0;
        bus.SUM_OUT      = acc_q;
        bus.SAT          = sat_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                acc_q <= acc_nx;
                cnt_q <= vec_end ? '0 : cnt_q + 1'b1;
                if (vec_end)
                    sat_q <= sat_nx;
            end
            if ((state_q == HOLD) && bus.SHIFT_READY) begin
                acc_q <= '0;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_softmax_recip.sv
// Directed bench for softmax_recip: sums, reciprocal values, latency, back-pressure and reset.
module tb_softmax_recip;
    localparam int WIDTH = 32;
    localparam int SHIFT = 16;
    localparam int N_MAX = 64;
`ifdef SOFTMAX_RECIP_ROUND_EN
    localparam int LAT = 18;
    localparam logic [15:0] SIX_EXP = 16'h2AAB;
`else
    localparam int LAT = 17;
    localparam logic [15:0] SIX_EXP = 16'h2AAA;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    softmax_recip_if #(.WIDTH(WIDTH), .SHIFT(SHIFT), .N_MAX(N_MAX)) bus ();

    softmax_recip #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (16),
        .SHIFT     (SHIFT),
        .N_MAX     (N_MAX)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, output int hs);
        int n = 0;
        bus.DAT_IN       = d;
        bus.DAT_IN_LAST  = last;
        bus.DAT_IN_VALID = 1'b1;
        while (bus.DAT_IN_READY !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout ready never rose within %0d cycles", n);
        end
        hs = cyc;
        tick();
        bus.DAT_IN_VALID = 1'b0;
        bus.DAT_IN_LAST  = 1'b0;
    endtask

    task automatic wait_valid(output int vc);
        int n = 0;
        while (bus.SHIFT_VALID !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL valid_timeout SHIFT_VALID not seen within %0d cycles", n);
        end
        vc = cyc;
    endtask

    task automatic run_vec(input int cnt, input logic [31:0] d, output int hs, output int vc);
        for (int i = 0; i < cnt; i++)
            send(d, (i == cnt - 1), hs);
        wait_valid(vc);
    endtask

    task automatic test_reset();
        bus.DAT_IN = '0;
        bus.DAT_IN_VALID = 1'b0;
        bus.DAT_IN_LAST = 1'b0;
        bus.SHIFT_READY = 1'b1;
        #2;
        checks++;
        if (bus.DAT_IN_READY !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", bus.DAT_IN_READY);
        end
        checks++;
        if (bus.SHIFT_VALID !== 1'b0 || bus.SHIFT_VAL !== 16'h0) begin
            errors++; $display("FAIL reset_shift got valid=%b val=%h exp 0/0000", bus.SHIFT_VALID, bus.SHIFT_VAL);
        end
        checks++;
        if (bus.SUM_OUT !== 38'h0 || bus.SAT !== 1'b0) begin
            errors++; $display("FAIL reset_sum got sum=%h sat=%b exp 0/0", bus.SUM_OUT, bus.SAT);
        end
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_two();
        int hs, vc;
        run_vec(2, 32'h10000, hs, vc);
        checks++;
        if (bus.SUM_OUT !== 38'h20000) begin
            errors++; $display("FAIL two_sum got=%h exp=20000", bus.SUM_OUT);
        end
        checks++;
        if (bus.SHIFT_VAL !== 16'h8000) begin
            errors++; $display("FAIL two_val got=%h exp=8000", bus.SHIFT_VAL);
        end
        checks++;
        if (bus.SAT !== 1'b0) begin
            errors++; $display("FAIL two_sat got=%b exp=0", bus.SAT);
        end
        checks++;
        if (vc - hs != LAT) begin
            errors++; $display("FAIL two_latency got=%0d exp=%0d", vc - hs, LAT);
        end
        tick();
        checks++;
        if (bus.SHIFT_VALID !== 1'b0 || bus.DAT_IN_READY !== 1'b1) begin
            errors++; $display("FAIL two_release got valid=%b ready=%b exp 0/1", bus.SHIFT_VALID, bus.DAT_IN_READY);
        end
    endtask

    task automatic test_values();
        int hs, vc;
        run_vec(4, 32'h10000, hs, vc);
        checks++;
        if (bus.SHIFT_VAL !== 16'h4000 || bus.SAT !== 1'b0) begin
            errors++; $display("FAIL four_val got val=%h sat=%b exp 4000/0", bus.SHIFT_VAL, bus.SAT);
        end
        tick();
        run_vec(1, 32'h10000, hs, vc);
        checks++;
        if (bus.SHIFT_VAL !== 16'hFFFF || bus.SAT !== 1'b1) begin
            errors++; $display("FAIL one_sat got val=%h sat=%b exp FFFF/1", bus.SHIFT_VAL, bus.SAT);
        end
        tick();
        run_vec(1, 32'h0, hs, vc);
        checks++;
        if (bus.SHIFT_VAL !== 16'hFFFF || bus.SAT !== 1'b1 || bus.SUM_OUT !== 38'h0) begin
            errors++; $display("FAIL zero_sat got val=%h sat=%b sum=%h exp FFFF/1/0", bus.SHIFT_VAL, bus.SAT, bus.SUM_OUT);
        end
        checks++;
        if (vc - hs != LAT) begin
            errors++; $display("FAIL zero_latency got=%0d exp=%0d", vc - hs, LAT);
        end
        tick();
        run_vec(6, 32'h10000, hs, vc);
        checks++;
        if (bus.SHIFT_VAL !== SIX_EXP) begin
            errors++; $display("FAIL six_val got=%h exp=%h", bus.SHIFT_VAL, SIX_EXP);
        end
        checks++;
        if (vc - hs != LAT) begin
            errors++; $display("FAIL six_latency got=%0d exp=%0d", vc - hs, LAT);
        end
        tick();
    endtask

    task automatic test_nmax();
        int hs, vc;
        for (int i = 0; i < 64; i++)
            send(32'h1000, 1'b0, hs);
        checks++;
        if (bus.DAT_IN_READY !== 1'b0) begin
            errors++; $display("FAIL nmax_ready got=%b exp=0", bus.DAT_IN_READY);
        end
        wait_valid(vc);
        checks++;
        if (bus.SUM_OUT !== 38'h40000 || bus.SHIFT_VAL !== 16'h4000) begin
            errors++; $display("FAIL nmax_result got sum=%h val=%h exp 40000/4000", bus.SUM_OUT, bus.SHIFT_VAL);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int hs, vc;
        bus.SHIFT_READY = 1'b0;
        run_vec(2, 32'h10000, hs, vc);
        bus.DAT_IN       = 32'h30000;
        bus.DAT_IN_LAST  = 1'b1;
        bus.DAT_IN_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.SHIFT_VALID !== 1'b1 || bus.SHIFT_VAL !== 16'h8000 || bus.SUM_OUT !== 38'h20000 ||
                bus.SAT !== 1'b0 || bus.DAT_IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got valid=%b val=%h sum=%h sat=%b ready=%b exp 1/8000/20000/0/0",
                         i, bus.SHIFT_VALID, bus.SHIFT_VAL, bus.SUM_OUT, bus.SAT, bus.DAT_IN_READY);
            end
            tick();
        end
        bus.SHIFT_READY = 1'b1;
        tick();
        checks++;
        if (bus.SHIFT_VALID !== 1'b0 || bus.DAT_IN_READY !== 1'b1 || bus.SUM_OUT !== 38'h0) begin
            errors++; $display("FAIL hold_exit got valid=%b ready=%b sum=%h exp 0/1/0", bus.SHIFT_VALID, bus.DAT_IN_READY, bus.SUM_OUT);
        end
        tick();
        bus.DAT_IN_VALID = 1'b0;
        bus.DAT_IN_LAST  = 1'b0;
        checks++;
        if (bus.DAT_IN_READY !== 1'b0 || bus.SUM_OUT !== 38'h30000) begin
            errors++; $display("FAIL held_input_taken got ready=%b sum=%h exp 0/30000", bus.DAT_IN_READY, bus.SUM_OUT);
        end
        wait_valid(vc);
        checks++;
        if (bus.SHIFT_VAL !== 16'h5555 || bus.SAT !== 1'b0) begin
            errors++; $display("FAIL three_val got val=%h sat=%b exp 5555/0", bus.SHIFT_VAL, bus.SAT);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        int hs, vc;
        int seen = 0;
        for (int i = 0; i < 3; i++)
            send(32'h10000, (i == 2), hs);
        for (int i = 0; i < 4; i++)
            tick();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (bus.DAT_IN_READY !== 1'b1 || bus.SHIFT_VALID !== 1'b0 || bus.SHIFT_VAL !== 16'h0 ||
            bus.SUM_OUT !== 38'h0 || bus.SAT !== 1'b0) begin
            errors++;
            $display("FAIL mid_div_reset got ready=%b valid=%b val=%h sum=%h sat=%b exp 1/0/0000/0/0",
                     bus.DAT_IN_READY, bus.SHIFT_VALID, bus.SHIFT_VAL, bus.SUM_OUT, bus.SAT);
        end
        tick();
        RST = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.SHIFT_VALID === 1'b1)
                seen = 1;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_div_no_valid got pulse=%0d exp=0", seen);
        end
        run_vec(2, 32'h20000, hs, vc);
        checks++;
        if (bus.SHIFT_VAL !== 16'h4000 || bus.SUM_OUT !== 38'h40000) begin
            errors++; $display("FAIL after_reset_val got val=%h sum=%h exp 4000/40000", bus.SHIFT_VAL, bus.SUM_OUT);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_two();
        test_values();
        test_nmax();
        test_backpressure();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
